// File: rtl/vector_player_pkg.sv
// Shared types for the vector_player stimulus/response engine.
// Default widths here; every module re-sizes through its own parameters.
package vector_player_pkg;

  localparam int IN_W_D  = 2;
  localparam int OUT_W_D = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [IN_W_D-1:0]  stim;
    logic [OUT_W_D-1:0] exp;
    logic [OUT_W_D-1:0] mask;
  } vector_entry_t;

  function automatic int clamp_num(input int n, input int lim);
    return (n > lim) ? lim : n;
  endfunction

endpackage

// File: rtl/vector_mem.sv
// Vector storage: one synchronous write port, one combinational read port.
// No reset, so loaded vectors survive a controller reset.
module vector_mem
  import vector_player_pkg::*;
#(
  parameter int IN_W  = IN_W_D,
  parameter int OUT_W = OUT_W_D,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [IN_W-1:0]  i_stim,
  input  logic [OUT_W-1:0] i_exp,
  input  logic [OUT_W-1:0] i_mask,
  input  logic [AW-1:0]    i_raddr,
  output logic [IN_W-1:0]  o_stim,
  output logic [OUT_W-1:0] o_exp,
  output logic [OUT_W-1:0] o_mask
);

  typedef struct packed {
    logic [IN_W-1:0]  stim;
    logic [OUT_W-1:0] exp;
    logic [OUT_W-1:0] mask;
  } entry_t;

  entry_t r_mem [DEPTH];
  entry_t w_rd;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= {i_stim, i_exp, i_mask};
  end

  assign w_rd   = r_mem[i_raddr];
  assign o_stim = w_rd.stim;
  assign o_exp  = w_rd.exp;
  assign o_mask = w_rd.mask;

endmodule

// File: rtl/vector_player.sv
// Plays stored vectors onto a DUT bus with programmable hold and
// compares the masked response, counting and locating mismatches.
module vector_player
  import vector_player_pkg::*;
#(
  parameter int IN_W   = IN_W_D,
  parameter int OUT_W  = OUT_W_D,
  parameter int DEPTH  = 16,
  parameter int HOLD_W = 4,
  parameter int ERR_W  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [IN_W-1:0]   ld_stim,
  input  logic [OUT_W-1:0]  ld_exp,
  input  logic [OUT_W-1:0]  ld_mask,
  input  logic              start,
  input  logic              stop,
  input  logic [AW:0]       num_vec,
  input  logic [HOLD_W-1:0] hold_cycles,
  input  logic              loop_en,
  output logic [IN_W-1:0]   stim_out,
  input  logic [OUT_W-1:0]  resp_in,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     vec_idx,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              first_err_valid,
  output logic [AW-1:0]     first_err_idx
);

  state_t            r_state;
  logic [AW:0]       r_num;
  logic [HOLD_W-1:0] r_hold_ld;
  logic [HOLD_W-1:0] r_hold;
  logic              r_loop;
  logic [IN_W-1:0]   r_stim;
  logic [OUT_W-1:0]  r_exp;
  logic [OUT_W-1:0]  r_mask;
  logic [AW-1:0]     r_idx;
  logic              r_busy;
  logic              r_done;
  logic [ERR_W-1:0]  r_err;
  logic              r_fv;
  logic [AW-1:0]     r_fidx;

  logic              w_we;
  logic              w_last;
  logic              w_mis;
  logic [AW:0]       w_num;
  logic [AW-1:0]     w_raddr;
  logic [IN_W-1:0]   w_stim;
  logic [OUT_W-1:0]  w_exp;
  logic [OUT_W-1:0]  w_mask;

  assign w_we   = ld_en && (r_state != S_RUN);
  assign w_num  = (AW+1)'(clamp_num(int'(num_vec), DEPTH));
  assign w_last = ({1'b0, r_idx} == r_num - 1'b1);
  assign w_mis  = |((resp_in ^ r_exp) & r_mask);

  // Read port always points at the vector to load on the next edge.
  assign w_raddr = (r_state == S_RUN && !w_last) ? r_idx + 1'b1 : '0;

  vector_mem #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (ld_addr),
    .i_stim  (ld_stim),
    .i_exp   (ld_exp),
    .i_mask  (ld_mask),
    .i_raddr (w_raddr),
    .o_stim  (w_stim),
    .o_exp   (w_exp),
    .o_mask  (w_mask)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_num     <= '0;
      r_hold_ld <= '0;
      r_hold    <= '0;
      r_loop    <= 1'b0;
      r_stim    <= '0;
      r_exp     <= '0;
      r_mask    <= '0;
      r_idx     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= '0;
      r_fv      <= 1'b0;
      r_fidx    <= '0;
    end else begin
      unique case (r_state)
        S_RUN: begin
          if (stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_hold != '0) begin
            r_hold <= r_hold - 1'b1;
          end else begin
            if (w_mis) begin
              if (r_err != '1) r_err <= r_err + 1'b1;
              if (!r_fv) begin
                r_fv   <= 1'b1;
                r_fidx <= r_idx;
              end
            end
            if (w_last && !r_loop) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx  <= w_raddr;
              r_stim <= w_stim;
              r_exp  <= w_exp;
              r_mask <= w_mask;
              r_hold <= r_hold_ld;
            end
          end
        end
        default: begin
          if (start && !stop) begin
            r_err     <= '0;
            r_fv      <= 1'b0;
            r_fidx    <= '0;
            r_idx     <= '0;
            r_num     <= w_num;
            r_hold_ld <= hold_cycles;
            r_loop    <= loop_en;
            if (w_num == '0) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
              r_stim  <= w_stim;
              r_exp   <= w_exp;
              r_mask  <= w_mask;
              r_hold  <= hold_cycles;
            end
          end
        end
      endcase
    end
  end

  assign stim_out        = r_stim;
  assign busy            = r_busy;
  assign done            = r_done;
  assign vec_idx         = r_idx;
  assign err_cnt         = r_err;
  assign first_err_valid = r_fv;
  assign first_err_idx   = r_fidx;

endmodule

// File: tb/tb_vector_player.sv
// Bench for vector_player driving a 2-input OR as the DUT: directed table,
// loop/stop/reset sequences, and random runs against a vector-list model.
module tb_vector_player;

  localparam int IN_W   = 2;
  localparam int OUT_W  = 1;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;
  localparam int HOLD_W = 4;
  localparam int ERR_W  = 2;
  localparam int ERR_MAX = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ld_en = 1'b0;
  logic [AW-1:0]     ld_addr = '0;
  logic [IN_W-1:0]   ld_stim = '0;
  logic [OUT_W-1:0]  ld_exp = '0;
  logic [OUT_W-1:0]  ld_mask = '0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [AW:0]       num_vec = '0;
  logic [HOLD_W-1:0] hold_cycles = '0;
  logic              loop_en = 1'b0;
  logic [IN_W-1:0]   stim_out;
  logic [OUT_W-1:0]  resp_in;
  logic              busy;
  logic              done;
  logic [AW-1:0]     vec_idx;
  logic [ERR_W-1:0]  err_cnt;
  logic              first_err_valid;
  logic [AW-1:0]     first_err_idx;

  vector_player #(
    .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH),
    .HOLD_W(HOLD_W), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .rst(rst),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_stim(ld_stim),
    .ld_exp(ld_exp), .ld_mask(ld_mask),
    .start(start), .stop(stop), .num_vec(num_vec),
    .hold_cycles(hold_cycles), .loop_en(loop_en),
    .stim_out(stim_out), .resp_in(resp_in),
    .busy(busy), .done(done), .vec_idx(vec_idx),
    .err_cnt(err_cnt), .first_err_valid(first_err_valid),
    .first_err_idx(first_err_idx)
  );

  // The DUT under test: a 2-input OR gate.
  assign resp_in = |stim_out;

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] m_stim [DEPTH];
  logic       m_exp  [DEPTH];
  logic       m_mask [DEPTH];
  int         last_stim = 0;

  typedef struct {
    string      nm;
    logic [3:0] ex;
    logic [3:0] mk;
    int         hold;
    int         num;
    int         e_err;
    bit         e_fv;
    int         e_fi;
  } row_t;

  row_t tbl [7];

  task automatic chk(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [1:0] s,
                      input logic e, input logic m);
    ld_en = 1'b1;
    ld_addr = 4'(a);
    ld_stim = s;
    ld_exp = e;
    ld_mask = m;
    step();
    ld_en = 1'b0;
    m_stim[a] = s;
    m_exp[a] = e;
    m_mask[a] = m;
  endtask

  // Entry i gets stim=i; entry 0 is written last, on the edge before start.
  task automatic load_pat(input logic [3:0] ex, input logic [3:0] mk);
    for (int i = 3; i >= 0; i--) begin
      logic [3:0] ev;
      logic [3:0] mv;
      ev = ex;
      mv = mk;
      load(i, 2'(i), ev[i], mv[i]);
    end
  endtask

  task automatic run(input string nm, input int n, input int h,
                     input int e_err, input bit e_fv, input int e_fi,
                     input bit scrib);
    int nn;
    int cyc;
    int k;
    int v;
    nn = (n > DEPTH) ? DEPTH : n;
    cyc = nn * (h + 1);
    num_vec = 5'(n);
    hold_cycles = 4'(h);
    loop_en = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (!done && k < cyc + 4) begin
      v = (k / (h + 1)) % DEPTH;
      chk({nm, "_stim"}, int'(stim_out), int'(m_stim[v]));
      chk({nm, "_idx"}, int'(vec_idx), v);
      chk({nm, "_busy"}, int'(busy), 1);
      if (scrib) begin
        ld_en = 1'b1;
        ld_addr = 4'($urandom);
        ld_stim = 2'($urandom);
        ld_exp = 1'($urandom);
        ld_mask = 1'($urandom);
      end
      step();
      k++;
    end
    ld_en = 1'b0;
    chk({nm, "_cycles"}, k, cyc);
    chk({nm, "_done"}, int'(done), 1);
    chk({nm, "_busy_end"}, int'(busy), 0);
    chk({nm, "_err"}, int'(err_cnt), e_err);
    chk({nm, "_fv"}, int'(first_err_valid), int'(e_fv));
    if (e_fv) chk({nm, "_fidx"}, int'(first_err_idx), e_fi);
    if (nn > 0) last_stim = int'(m_stim[nn-1]);
    chk({nm, "_stim_end"}, int'(stim_out), last_stim);
  endtask

  initial begin
    tbl[0] = '{"or_ok",  4'b1110, 4'b1111, 0, 4, 0, 1'b0, 0};
    tbl[1] = '{"bad2",   4'b1010, 4'b1111, 0, 4, 1, 1'b1, 2};
    tbl[2] = '{"mask2",  4'b1010, 4'b1011, 0, 4, 0, 1'b0, 0};
    tbl[3] = '{"hold3",  4'b1110, 4'b1111, 3, 4, 0, 1'b0, 0};
    tbl[4] = '{"zero",   4'b1110, 4'b1111, 0, 0, 0, 1'b0, 0};
    tbl[5] = '{"two",    4'b1111, 4'b1111, 0, 2, 1, 1'b1, 0};
    tbl[6] = '{"allbad", 4'b0001, 4'b1111, 1, 4, 3, 1'b1, 0};

    #2;
    chk("rst_stim", int'(stim_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_idx", int'(vec_idx), 0);
    chk("rst_err", int'(err_cnt), 0);
    chk("rst_fv", int'(first_err_valid), 0);
    chk("rst_fidx", int'(first_err_idx), 0);
    rst = 1'b0;
    step();

    for (int r = 0; r < 7; r++) begin
      load_pat(tbl[r].ex, tbl[r].mk);
      run(tbl[r].nm, tbl[r].num, tbl[r].hold,
          tbl[r].e_err, tbl[r].e_fv, tbl[r].e_fi, 1'b0);
    end

    // Looping run with a bad entry 2: error count saturates.
    load_pat(4'b1010, 4'b1111);
    num_vec = 5'd4;
    hold_cycles = 4'd0;
    loop_en = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 80; i++) step();
    chk("loop_busy", int'(busy), 1);
    chk("loop_done", int'(done), 0);
    chk("loop_err", int'(err_cnt), ERR_MAX);
    chk("loop_fv", int'(first_err_valid), 1);
    chk("loop_fidx", int'(first_err_idx), 2);
    chk("loop_idx", int'(vec_idx), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("run_start_err", int'(err_cnt), ERR_MAX);
    chk("run_start_idx", int'(vec_idx), 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_busy", int'(busy), 0);
    chk("stop_done", int'(done), 0);
    chk("stop_err", int'(err_cnt), ERR_MAX);
    chk("stop_fidx", int'(first_err_idx), 2);
    chk("stop_stim", int'(stim_out), 1);
    loop_en = 1'b0;

    // start together with stop in IDLE: nothing happens.
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    chk("ss_busy", int'(busy), 0);
    chk("ss_done", int'(done), 0);
    chk("ss_err", int'(err_cnt), ERR_MAX);

    // Asynchronous reset during vector 1, then replay.
    load_pat(4'b0001, 4'b1111);
    num_vec = 5'd4;
    hold_cycles = 4'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("pre_rst_idx", int'(vec_idx), 1);
    chk("pre_rst_err", int'(err_cnt), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_stim", int'(stim_out), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_idx", int'(vec_idx), 0);
    chk("arst_err", int'(err_cnt), 0);
    chk("arst_fv", int'(first_err_valid), 0);
    chk("arst_done", int'(done), 0);
    rst = 1'b0;
    step();
    last_stim = 0;
    run("replay", 4, 1, 3, 1'b1, 0, 1'b0);

    // Random contents, lengths and holds; loads during RUN must be ignored.
    for (int r = 0; r < 12; r++) begin
      int n;
      int h;
      int nn;
      int e_err;
      bit e_fv;
      int e_fi;
      for (int a = 0; a < DEPTH; a++)
        load(a, 2'($urandom), 1'($urandom), 1'($urandom));
      n = $urandom_range(0, 31);
      h = $urandom_range(0, 2);
      nn = (n > DEPTH) ? DEPTH : n;
      e_err = 0;
      e_fv = 1'b0;
      e_fi = 0;
      for (int i = 0; i < nn; i++) begin
        if (((m_exp[i] ^ (|m_stim[i])) & m_mask[i]) == 1'b1) begin
          if (!e_fv) begin
            e_fv = 1'b1;
            e_fi = i;
          end
          e_err++;
        end
      end
      if (e_err > ERR_MAX) e_err = ERR_MAX;
      run($sformatf("rand%0d", r), n, h, e_err, e_fv, e_fi, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vector_player.md
# vector_player

Synthesizable, parametrised stimulus/response engine for bench and on-chip self-test. It holds up to DEPTH test vectors, each with an expected response and a don't-care mask. It drives the vectors onto a DUT input bus with a programmable hold time, samples the DUT response, and counts and records mismatches. It replaces file-driven, fixed-delay testbench loops with a reusable, cycle-exact block that works for any input and output width.

## Interface
Parameters:
- IN_W, 2, DUT input (stimulus) width
- OUT_W, 1, DUT output (response) width
- DEPTH, 16, vector storage entries; AW = $clog2(DEPTH)
- HOLD_W, 4, width of hold-cycle count
- ERR_W, 8, error counter width

Ports (one clock; reset asynchronous, active-high):
- clk  in  1  clock
- rst  in  1  async active-high reset
- ld_en  in  1  write one vector entry (honoured only in IDLE/DONE)
- ld_addr  in  AW  entry index
- ld_stim  in  IN_W  stimulus value
- ld_exp  in  OUT_W  expected response
- ld_mask  in  OUT_W  compare mask (1 = check bit)
- start  in  1  begin playback
- stop  in  1  abort playback
- num_vec  in  AW+1  vectors to play (latched at start)
- hold_cycles  in  HOLD_W  extra cycles per vector (latched at start)
- loop_en  in  1  wrap to entry 0 after last vector (latched at start)
- stim_out  out  IN_W  registered stimulus to DUT
- resp_in  in  OUT_W  DUT response
- busy  out  1  playback active
- done  out  1  run complete; held until next start
- vec_idx  out  AW  index of vector currently applied
- err_cnt  out  ERR_W  saturating mismatch count
- first_err_valid  out  1  at least one mismatch this run
- first_err_idx  out  AW  index of first mismatching vector

## Operation
- FSM states: IDLE, RUN, DONE. Reset puts the FSM in IDLE.
- Reset values: every output is 0.
- IDLE/DONE + start:
  - Go to RUN.
  - Latch num_vec (clamped to DEPTH), hold_cycles and loop_en.
  - Clear err_cnt, first_err_valid and done.
  - Set vec_idx=0 and stim_out=stim[0].
  - Load the hold counter with hold_cycles.
- start with num_vec=0: go directly to DONE with done=1. stim_out is unchanged and err_cnt=0.
- RUN, each edge:
  - If the hold counter is nonzero, decrement it.
  - Otherwise, evaluate ((resp_in ^ exp[vec_idx]) & mask[vec_idx]) != 0.
  - On a mismatch: err_cnt+1, saturating at 2^ERR_W-1. On the first mismatch of the run, also set first_err_valid=1 and first_err_idx=vec_idx.
  - Then advance to the next vector, reload the hold counter and set stim_out=stim[next].
- Last vector (vec_idx=num_vec-1) evaluated:
  - loop_en=1: wrap to 0. err_cnt keeps accumulating.
  - loop_en=0: go to DONE with done=1 and busy=0. stim_out holds the last vector.
- stop in RUN: go to IDLE on the next edge. No compare happens on that edge. err_cnt and first_err_* are retained, done stays 0, stim_out holds its value.
- start and stop asserted together: stop wins. start in RUN is ignored.
- ld_en in RUN is ignored. Memory contents survive reset. Only control and status registers reset.
- busy=1 exactly when the state is RUN.

## Timing
- Vector k is driven for hold_cycles+1 cycles.
- resp_in is sampled at the final rising edge of vector k's window. The DUT therefore gets hold_cycles+1 cycles of combinational/registered settling.
- Latency from start to the first stim_out change is 1 edge.
- Total run length is num_vec·(hold_cycles+1) cycles from the start edge to the done edge.
- A load written on edge t is readable by a start sampled on edge t+1.
- Async reset mid-run: all outputs clear immediately. No partial-count retention.

## Structure
- Package vector_player_pkg holds:
  - the state enum (IDLE, RUN, DONE)
  - a vector_entry_t struct {stim, exp, mask}, sized by package parameters with per-instance override
- Sub-module vector_mem provides DEPTH x (IN_W+2·OUT_W) storage with one synchronous write port and one combinational read port, addressed by next index.
- The top-level module contains the FSM, hold counter, index counter, compare and error logic.

## Test plan
Base configuration: IN_W=2, OUT_W=1, DEPTH=16; DUT is a 2-input OR.
- Load 4 OR truth-table vectors (00→0, 01→1, 10→1, 11→1), mask=1, num_vec=4, hold=0, start → stim_out 0,1,2,3 on consecutive cycles; done after 4 cycles; err_cnt=0.
- Same set with entry 2 exp=0 → err_cnt=1, first_err_valid=1, first_err_idx=2.
- Same as above but mask[2]=0 → err_cnt=0.
- hold_cycles=3 → each vector held 4 cycles; done 16 cycles after start; vec_idx steps every 4 cycles.
- loop_en=1, bad entry 2, ERR_W=2, run 20 loops → err_cnt saturates at 3; first_err_idx stays 2; stop → IDLE next edge with busy=0 and done=0.
- Assert rst during vector 1 of a 4-vector run → all outputs 0 immediately; a fresh start replays from vector 0 with the memory contents intact.
